// File: rtl/r2sdf_bf_stage.sv
// Radix-2 SDF decimation-in-frequency butterfly stage with a DELAY-deep feedback line.
// Emits halved sums/differences plus the twiddle select/index for the downstream multiplier.
module r2sdf_bf_stage #(
  parameter int width      = 16,
  parameter int DELAY      = 8,
  parameter int LOG2_DELAY = 3,
  localparam int IW        = (LOG2_DELAY > 0) ? LOG2_DELAY : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    flush,
  input  logic signed [width-1:0] in_re,
  input  logic signed [width-1:0] in_im,
  output logic                    out_valid,
  output logic signed [width-1:0] out_re,
  output logic signed [width-1:0] out_im,
  output logic                    tw_sel,
  output logic [IW-1:0]           tw_idx
);

  logic [LOG2_DELAY:0]     cnt_reg;
  logic                    primed_reg;
  logic signed [width-1:0] dl_re_reg [DELAY];
  logic signed [width-1:0] dl_im_reg [DELAY];

  logic                    step;
  logic                    phase;
  logic [IW-1:0]           k;
  logic signed [width-1:0] x_re, x_im;
  logic signed [width-1:0] head_re, head_im;
  logic signed [width:0]   sum_re_w, sum_im_w, dif_re_w, dif_im_w;
  logic signed [width-1:0] fb_re, fb_im;

  assign step  = in_valid | flush;
  assign phase = cnt_reg[LOG2_DELAY];

  generate
    if (LOG2_DELAY > 0) begin : g_k
      assign k = cnt_reg[IW-1:0];
    end else begin : g_k0
      assign k = '0;
    end
  endgenerate

  // Flush-only cycles push zeros so draining never mixes in stale input data.
  assign x_re    = in_valid ? in_re : '0;
  assign x_im    = in_valid ? in_im : '0;
  assign head_re = dl_re_reg[0];
  assign head_im = dl_im_reg[0];

  // One guard bit, then dropping the LSB gives the floor of the halved result.
  assign sum_re_w = {head_re[width-1], head_re} + {x_re[width-1], x_re};
  assign sum_im_w = {head_im[width-1], head_im} + {x_im[width-1], x_im};
  assign dif_re_w = {head_re[width-1], head_re} - {x_re[width-1], x_re};
  assign dif_im_w = {head_im[width-1], head_im} - {x_im[width-1], x_im};

  assign fb_re = phase ? dif_re_w[width:1] : x_re;
  assign fb_im = phase ? dif_im_w[width:1] : x_im;

  // Entry 0 is the oldest sample; new data enters at the top.
  generate
    for (genvar gi = 0; gi < DELAY; gi++) begin : g_dl
      always_ff @(posedge clk) begin
        if (rst) begin
          dl_re_reg[gi] <= '0;
          dl_im_reg[gi] <= '0;
        end else if (step) begin
          if (gi == DELAY - 1) begin
            dl_re_reg[gi] <= fb_re;
            dl_im_reg[gi] <= fb_im;
          end else begin
            dl_re_reg[gi] <= dl_re_reg[(gi + 1) % DELAY];
            dl_im_reg[gi] <= dl_im_reg[(gi + 1) % DELAY];
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg    <= '0;
      primed_reg <= 1'b0;
      out_valid  <= 1'b0;
      out_re     <= '0;
      out_im     <= '0;
      tw_sel     <= 1'b0;
      tw_idx     <= '0;
    end else begin
      out_valid <= step & (primed_reg | phase);
      if (step) begin
        cnt_reg <= cnt_reg + (LOG2_DELAY + 1)'(1);
        if (phase) begin
          primed_reg <= 1'b1;
          out_re     <= sum_re_w[width:1];
          out_im     <= sum_im_w[width:1];
          tw_sel     <= 1'b0;
          tw_idx     <= '0;
        end else begin
          out_re     <= head_re;
          out_im     <= head_im;
          tw_sel     <= 1'b1;
          tw_idx     <= k;
        end
      end
    end
  end

endmodule
